mem32_byte_reader: RTL and testbench

Streams a contiguous range of 32-bit words from a synchronous-read word memory as bytes, least-significant byte first. Each byte leaves on a valid/ready byte port together with its byte address. This is the unpacking counterpart of the byte-to-word packing used when loading program images: the testbench uses it to dump word memory back into a byte image with the same byte order. It sits between a single-port 32-bit memory read port and a byte sink such as a file-writer or checker.

---
 rtl/mem32_byte_reader.sv | 121 ++++++++++++
 tb/tb_mem32_byte_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem32_byte_reader.sv
// Streams a range of 32-bit words from a sync-read memory as bytes,
// least-significant byte first, each tagged with its byte address.
module mem32_byte_reader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   num_words_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              byte_valid_o,
  output logic [7:0]        byte_data_o,
  output logic [ADDR_W+1:0] byte_addr_o,
  input  logic              byte_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;
  logic [31:0]       r_word;
  logic [1:0]        r_lane;
  logic              w_go;
  logic              w_xfer;
  logic              w_last;

  assign w_go   = start_i && (num_words_i != '0);
  assign w_xfer = (r_state == S_SEND) && byte_ready_i;
  assign w_last = w_xfer && (r_lane == 2'd3);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    byte_valid_o = 1'b0;
    byte_data_o  = '0;
    byte_addr_o  = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next = w_go ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = r_addr;
        busy_o     = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        w_next = S_SEND;
      end
      S_SEND: begin
        busy_o       = 1'b1;
        byte_valid_o = 1'b1;
        byte_data_o  = r_word[{r_lane, 3'b000} +: 8];
        byte_addr_o  = {r_addr, r_lane};
        if (w_last) begin
          w_next = (r_rem == (ADDR_W+1)'(1)) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word address and count advance only once the last lane is accepted,
  // so the address shown with each byte is the word it came from.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_word <= '0;
      r_lane <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_go) begin
        r_addr <= base_addr_i;
        r_rem  <= num_words_i;
      end
      if (r_state == S_WAIT) begin
        r_word <= mem_rdata_i;
        r_lane <= '0;
      end
      if (w_xfer) begin
        r_lane <= r_lane + 2'd1;
      end
      if (w_last) begin
        r_rem  <= r_rem - (ADDR_W+1)'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem32_byte_reader.sv
// Directed bench for mem32_byte_reader: timing, order, stalls,
// wrap-around, reset, ignored starts and a full-depth run.
module tb_mem32_byte_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base = '0;
  logic [16:0] num = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] rdata = '0;
  logic        valid;
  logic [7:0]  bdata;
  logic [17:0] baddr;
  logic        rdy = 1'b1;
  logic        busy;
  logic        done;

  logic        s_start = 1'b0;
  logic [3:0]  s_base = '0;
  logic [4:0]  s_num = '0;
  logic        s_req;
  logic [3:0]  s_maddr;
  logic [31:0] s_rdata = '0;
  logic        s_valid;
  logic [7:0]  s_bdata;
  logic [5:0]  s_baddr;
  logic        s_busy;
  logic        s_done;

  logic [31:0] mem [0:65535];
  logic [31:0] mem_s [0:15];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  int          req_cyc[$];
  logic [15:0] req_adr[$];
  logic [7:0]  b_dat[$];
  logic [17:0] b_adr[$];
  int          b_cyc[$];
  int          done_cyc[$];

  int         s_cnt = 0;
  int         s_bad = 0;
  int         s_nreq = 0;
  logic [5:0] s_last = '0;

  mem32_byte_reader #(.ADDR_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_addr_i(base), .num_words_i(num),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_rdata_i(rdata), .byte_valid_o(valid),
    .byte_data_o(bdata), .byte_addr_o(baddr),
    .byte_ready_i(rdy), .busy_o(busy), .done_o(done)
  );

  mem32_byte_reader #(.ADDR_W(4)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(s_start),
    .base_addr_i(s_base), .num_words_i(s_num),
    .mem_req_o(s_req), .mem_addr_o(s_maddr),
    .mem_rdata_i(s_rdata), .byte_valid_o(s_valid),
    .byte_data_o(s_bdata), .byte_addr_o(s_baddr),
    .byte_ready_i(1'b1), .busy_o(s_busy), .done_o(s_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req) rdata <= mem[mem_addr];
    if (s_req) s_rdata <= mem_s[s_maddr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        req_cyc.push_back(cyc);
        req_adr.push_back(mem_addr);
      end
      if (valid && rdy) begin
        b_dat.push_back(bdata);
        b_adr.push_back(baddr);
        b_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (s_req) s_nreq++;
      if (s_valid) begin
        s_cnt++;
        s_last = s_baddr;
        if (s_bdata != 8'({2'b00, s_baddr} + 8'hA0)) s_bad++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_cyc.delete();
    req_adr.delete();
    b_dat.delete();
    b_adr.delete();
    b_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic do_start(input logic [15:0] b, input logic [16:0] n,
                          output int t);
    base  = b;
    num   = n;
    start = 1'b1;
    t     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > lim) begin
        chk("timeout", {63'd0, done}, 64'd1);
        break;
      end
    end
    tick();
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] ed[8],
                           input logic [17:0] ea[8], input int cnt);
    chk({tag, "_nbytes"}, b_dat.size(), cnt);
    for (int i = 0; i < cnt && i < b_dat.size(); i++) begin
      chk({tag, "_data"}, b_dat[i], ed[i]);
      chk({tag, "_addr"}, b_adr[i], ea[i]);
    end
  endtask

  initial begin
    int t;
    logic [7:0]  ed[8];
    logic [17:0] ea[8];

    mem[16'h0010] = 32'h44332211;
    mem[16'h0020] = 32'hDDCCBBAA;
    mem[16'h0021] = 32'h87654321;
    mem[16'hFFFF] = 32'h04030201;
    mem[16'h0000] = 32'h08070605;
    mem[16'h0030] = 32'h0D0C0B0A;
    mem[16'h0031] = 32'h78563412;
    mem[16'h0040] = 32'hF3F2F1F0;
    for (int w = 0; w < 16; w++) begin
      for (int l = 0; l < 4; l++) begin
        mem_s[w][8*l +: 8] = 8'(4*w + l + 8'hA0);
      end
    end

    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", {mem_req, mem_addr, valid, bdata, baddr, busy, done},
        64'd0);
    tick();
    rst = 1'b0;
    tick();

    // single word, then zero count started in the first allowed cycle
    clr();
    do_start(16'h0010, 17'd1, t);
    wait_done(20);
    chk("single_nreq", req_cyc.size(), 1);
    if (req_cyc.size() > 0) begin
      chk("single_req_cyc", req_cyc[0], t + 1);
      chk("single_req_addr", req_adr[0], 16'h0010);
    end
    ed = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0};
    ea = '{18'h40, 18'h41, 18'h42, 18'h43, 0, 0, 0, 0};
    chk_bytes("single", ed, ea, 4);
    for (int i = 0; i < 4 && i < b_cyc.size(); i++)
      chk("single_byte_cyc", b_cyc[i], t + 3 + i);
    if (done_cyc.size() > 0) chk("single_done_cyc", done_cyc[0], t + 7);
    chk("single_idle_busy", {63'd0, busy}, 64'd0);

    clr();
    do_start(16'h1234, 17'd0, t);
    wait_done(5);
    chk("zero_ndone", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("zero_done_cyc", done_cyc[0], t + 1);
    chk("zero_nreq", req_cyc.size(), 0);
    chk("zero_nbytes", b_dat.size(), 0);

    // backpressure while lane 2 of the first word is shown
    clr();
    do_start(16'h0020, 17'd2, t);
    repeat (4) tick();
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, valid}, 64'd1);
      chk("stall_data", bdata, 8'hCC);
      chk("stall_addr", baddr, 18'h82);
      chk("stall_req", {63'd0, mem_req}, 64'd0);
      tick();
    end
    rdy = 1'b1;
    wait_done(40);
    ed = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h21, 8'h43, 8'h65, 8'h87};
    ea = '{18'h80, 18'h81, 18'h82, 18'h83,
           18'h84, 18'h85, 18'h86, 18'h87};
    chk_bytes("bp", ed, ea, 8);
    chk("bp_nreq", req_cyc.size(), 2);
    if (req_cyc.size() > 1) chk("bp_req2_cyc", req_cyc[1], t + 10);
    if (done_cyc.size() > 0) chk("bp_done_cyc", done_cyc[0], t + 16);

    // address wrap-around
    clr();
    do_start(16'hFFFF, 17'd2, t);
    wait_done(40);
    chk("wrap_nreq", req_cyc.size(), 2);
    if (req_cyc.size() > 1) begin
      chk("wrap_req0", req_adr[0], 16'hFFFF);
      chk("wrap_req1", req_adr[1], 16'h0000);
    end
    ed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    ea = '{18'h3FFFC, 18'h3FFFD, 18'h3FFFE, 18'h3FFFF,
           18'h00000, 18'h00001, 18'h00002, 18'h00003};
    chk_bytes("wrap", ed, ea, 8);
    if (done_cyc.size() > 0) chk("wrap_done_cyc", done_cyc[0], t + 13);

    // reset during lane 1
    clr();
    do_start(16'h0030, 17'd2, t);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_outs",
        {mem_req, mem_addr, valid, bdata, baddr, busy, done}, 64'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_mid_ndone", done_cyc.size(), 0);
    clr();
    do_start(16'h0031, 17'd1, t);
    wait_done(20);
    ed = '{8'h12, 8'h34, 8'h56, 8'h78, 0, 0, 0, 0};
    ea = '{18'hC4, 18'hC5, 18'hC6, 18'hC7, 0, 0, 0, 0};
    chk_bytes("rst_after", ed, ea, 4);
    if (done_cyc.size() > 0) chk("rst_after_done", done_cyc[0], t + 7);

    // start pulses during WAIT and SEND are ignored
    clr();
    do_start(16'h0040, 17'd1, t);
    tick();
    base = 16'h0050; num = 17'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    base = 16'h0051; num = 17'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20);
    repeat (4) tick();
    chk("busy_nreq", req_cyc.size(), 1);
    ed = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 0, 0, 0, 0};
    ea = '{18'h100, 18'h101, 18'h102, 18'h103, 0, 0, 0, 0};
    chk_bytes("busy", ed, ea, 4);
    chk("busy_ndone", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("busy_done_cyc", done_cyc[0], t + 7);

    // full-depth count on the narrow instance
    s_num = 5'h10;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int n = 0; n < 200 && !s_done; n++) @(negedge clk);
    chk("full_done", {63'd0, s_done}, 64'd1);
    tick();
    chk("full_nbytes", s_cnt, 64);
    chk("full_last_addr", s_last, 6'h3F);
    chk("full_data_bad", s_bad, 0);
    chk("full_nreq", s_nreq, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
